// File: rtl/ntt_bf_scheduler.sv
// Address and control sequencer for an in-place NTT/INTT: walks the butterfly
// pairs layer by layer, feeds an external butterfly unit and writes results back.
module ntt_bf_scheduler #(
    parameter int N          = 256,
    parameter int Q          = 3329,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(N),
    localparam int QW        = $clog2(Q),
    localparam int KW        = AW - 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    input  logic [QW-1:0] rd_data_a,
    input  logic [QW-1:0] rd_data_b,
    output logic [KW-1:0] tw_addr,
    input  logic [QW-1:0] tw_data,
    output logic [1:0]    bf_operation,
    output logic          bf_valid_in,
    output logic [QW-1:0] bf_a_in,
    output logic [QW-1:0] bf_b_in,
    output logic [QW-1:0] bf_omega,
    input  logic [QW-1:0] bf_a_out,
    input  logic [QW-1:0] bf_b_out,
    input  logic          bf_valid_out,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic [QW-1:0] wr_data_a,
    output logic [QW-1:0] wr_data_b,
    output logic [1:0]    dbg_state
);

    // Butterfly handshake: a request is one cycle of bf_valid_in with its operands;
    // each bf_valid_out is matched in order to the oldest pair still in flight.
    localparam int PAIRS = N / 2;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW    = $clog2(AW);
    localparam logic [LW-1:0] LAST_LAYER = LW'(AW - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            mode_r;
    logic [AW-1:0]   len_r;
    logic [KW-1:0]   p_r;
    logic [KW-1:0]   k_r;
    logic [LW-1:0]   layer_r;
    logic [CW-1:0]   count, count_nxt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [2*AW-1:0] fifo_mem [FIFO_DEPTH];

    logic [AW-1:0] p_ext, len_mask, pair_a, pair_b;
    logic          issue, pop, group_end, last_pair;

    // Pair index p splits into group bits (above len) and offset bits (below len);
    // inserting a zero at the len bit gives the lower address of the pair.
    assign p_ext     = {1'b0, p_r};
    assign len_mask  = len_r - 1'b1;
    assign pair_a    = ((p_ext & ~len_mask) << 1) | (p_ext & len_mask);
    assign pair_b    = pair_a | len_r;
    assign group_end = (p_ext & len_mask) == len_mask;
    assign last_pair = &p_r;

    assign issue = (state == S_ISSUE) && (count != CW'(FIFO_DEPTH));
    assign pop   = bf_valid_out && (count != '0);

    always_comb begin
        count_nxt = count;
        case ({issue, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (issue && last_pair) state_nxt = S_DRAIN;
            S_DRAIN: if (count_nxt == '0)
                         state_nxt = (layer_r == LAST_LAYER) ? S_DONE : S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy         = (state == S_ISSUE) || (state == S_DRAIN);
    assign done         = (state == S_DONE);
    assign dbg_state    = state;
    assign rd_en        = issue;
    assign rd_addr_a    = issue ? pair_a : '0;
    assign rd_addr_b    = issue ? pair_b : '0;
    assign tw_addr      = issue ? k_r : '0;
    assign bf_operation = {1'b0, mode_r};
    assign bf_a_in      = bf_valid_in ? rd_data_a : '0;
    assign bf_b_in      = bf_valid_in ? rd_data_b : '0;
    assign bf_omega     = bf_valid_in ? tw_data : '0;
    assign wr_en        = pop;
    assign wr_addr_a    = pop ? fifo_mem[rd_ptr][2*AW-1:AW] : '0;
    assign wr_addr_b    = pop ? fifo_mem[rd_ptr][AW-1:0] : '0;
    assign wr_data_a    = pop ? bf_a_out : '0;
    assign wr_data_b    = pop ? bf_b_out : '0;

    always_ff @(posedge clk) begin
        if (issue) fifo_mem[wr_ptr] <= {pair_a, pair_b};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_r      <= 1'b0;
            len_r       <= '0;
            p_r         <= '0;
            k_r         <= '0;
            layer_r     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bf_valid_in <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            bf_valid_in <= issue;
            if (bf_valid_out && count == '0) err <= 1'b1;
            if (issue) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)   rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            if (state == S_IDLE && start) begin
                mode_r  <= mode;
                len_r   <= mode ? AW'(2) : AW'(PAIRS);
                k_r     <= mode ? KW'(PAIRS - 1) : KW'(1);
                p_r     <= '0;
                layer_r <= '0;
            end
            // p wraps to zero on the last pair, ready for the next layer.
            if (issue) begin
                p_r <= p_r + 1'b1;
                if (group_end) k_r <= mode_r ? k_r - 1'b1 : k_r + 1'b1;
            end
            if (state == S_DRAIN && count_nxt == '0 && layer_r != LAST_LAYER) begin
                layer_r <= layer_r + 1'b1;
                len_r   <= mode_r ? (len_r << 1) : (len_r >> 1);
            end
        end
    end

endmodule
